// File: rtl/booth_arb_pkg.sv
// booth_arb_pkg: shared types and constants for the booth arbiter.
// Holds the FSM state encoding and the two-bit vote codes carried on vote_sel.
package booth_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    WAIT    = 3'd2,
    CAST    = 3'd3,
    RELEASE = 3'd4
  } arb_state_t;

  localparam logic [1:0] VOTE_NONE = 2'b00;
  localparam logic [1:0] VOTE_C1   = 2'b01;
  localparam logic [1:0] VOTE_C2   = 2'b10;
  localparam logic [1:0] VOTE_C3   = 2'b11;

  localparam logic [7:0] COUNT_MAX = 8'hFF;

endpackage

// File: rtl/booth_arbiter_if.sv
// booth_arbiter_if: bus between the booth arbiter and its environment.
// Handshake: a booth holds req[i] high to ask for service; grant[i] answers one
// cycle later and stays high until the vote is cast, times out or is aborted
// (req may drop after grant without effect). candidate_ready is a one-cycle arm
// pulse to the EVM; the EVM accepts by raising evm_busy, sampled each cycle while
// waiting. vote_cN, ack[i] and err are one-cycle completion pulses with no
// back-pressure. dbg_state/dbg_pointer expose the arbiter FSM and round-robin pointer.
interface booth_arbiter_if #(parameter int NUM_BOOTHS = 4);
  import booth_arb_pkg::*;

  logic                          enable;
  logic [NUM_BOOTHS-1:0]         req;
  logic [2*NUM_BOOTHS-1:0]       vote_sel;
  logic                          evm_busy;
  logic [NUM_BOOTHS-1:0]         grant;
  logic                          candidate_ready;
  logic                          vote_c1;
  logic                          vote_c2;
  logic                          vote_c3;
  logic [NUM_BOOTHS-1:0]         ack;
  logic                          err;
  logic [7:0]                    served_count;
  arb_state_t                    dbg_state;
  logic [$clog2(NUM_BOOTHS)-1:0] dbg_pointer;

  modport master (
    output enable, req, vote_sel, evm_busy,
    input  grant, candidate_ready, vote_c1, vote_c2, vote_c3, ack, err,
           served_count, dbg_state, dbg_pointer
  );

  modport slave (
    input  enable, req, vote_sel, evm_busy,
    output grant, candidate_ready, vote_c1, vote_c2, vote_c3, ack, err,
           served_count, dbg_state, dbg_pointer
  );

endinterface

// File: rtl/booth_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector. Scans the request vector
// starting at the pointer and wrapping, returning the first requester as a
// one-hot vector and as an index.
module rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] pointer,
  output logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] index,
  output logic                 valid
);

  localparam int IW = $clog2(N);

  int pos;

  // First requester at or after the pointer wins; later hits are ignored.
  always_comb begin
    onehot = '0;
    index  = '0;
    valid  = 1'b0;
    pos    = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(pointer) + k) % N;
      if (!valid && req[pos]) begin
        valid       = 1'b1;
        index       = IW'(pos);
        onehot[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/booth_arbiter.sv
// booth_arbiter: round-robin arbiter feeding one EVM from NUM_BOOTHS voter booths.
// Sequence per vote: IDLE -> ARM (arm pulse) -> WAIT (for evm_busy) -> CAST
// (vote pulse) -> RELEASE (ack, pointer advance) -> IDLE. All outputs registered.
// Optional feature: define BOOTH_ARB_TIMEOUT_EN to give up waiting for the EVM
// after TIMEOUT cycles in WAIT (err pulse, no ack, no count).
module booth_arbiter
  import booth_arb_pkg::*;
#(
  parameter int NUM_BOOTHS = 4,
  parameter int TIMEOUT    = 100
) (
  input  logic           clk,
  input  logic           rst,
  booth_arbiter_if.slave bus
);

  localparam int IW = $clog2(NUM_BOOTHS);

  arb_state_t            state, state_nxt;
  logic [IW-1:0]         pointer, pointer_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic [1:0]            code, code_nxt;
  logic [NUM_BOOTHS-1:0] grant_q, grant_nxt;
  logic [NUM_BOOTHS-1:0] ack_q, ack_nxt;
  logic                  cand_q, cand_nxt;
  logic                  c1_q, c1_nxt;
  logic                  c2_q, c2_nxt;
  logic                  c3_q, c3_nxt;
  logic                  err_q, err_nxt;
  logic [7:0]            count_q, count_nxt;

`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]         timer, timer_nxt;
`endif

  logic [NUM_BOOTHS-1:0] pick_onehot;
  logic [IW-1:0]         pick_idx;
  logic                  pick_valid;

  rr_picker #(.N(NUM_BOOTHS)) u_picker (
    .req     (bus.req),
    .pointer (pointer),
    .onehot  (pick_onehot),
    .index   (pick_idx),
    .valid   (pick_valid)
  );

  // Next-state and next-output logic; pulse outputs default low every cycle.
  always_comb begin
    state_nxt   = state;
    pointer_nxt = pointer;
    idx_nxt     = idx;
    code_nxt    = code;
    grant_nxt   = grant_q;
    ack_nxt     = '0;
    cand_nxt    = 1'b0;
    c1_nxt      = 1'b0;
    c2_nxt      = 1'b0;
    c3_nxt      = 1'b0;
    err_nxt     = 1'b0;
    count_nxt   = count_q;
`ifdef BOOTH_ARB_TIMEOUT_EN
    timer_nxt   = '0;
`endif
    if (state != IDLE && !bus.enable) begin
      // Session closed mid-transaction: drop everything, keep the pointer.
      state_nxt = IDLE;
      grant_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.enable && pick_valid) begin
            idx_nxt   = pick_idx;
            code_nxt  = bus.vote_sel[{pick_idx, 1'b0} +: 2];
            grant_nxt = pick_onehot;
            cand_nxt  = 1'b1;
            state_nxt = ARM;
          end
        end
        ARM: begin
          state_nxt = WAIT;
        end
        WAIT: begin
          if (bus.evm_busy) begin
            state_nxt = CAST;
            case (code)
              VOTE_C1: c1_nxt  = 1'b1;
              VOTE_C2: c2_nxt  = 1'b1;
              VOTE_C3: c3_nxt  = 1'b1;
              default: err_nxt = 1'b1;
            endcase
`ifdef BOOTH_ARB_TIMEOUT_EN
          end else if (timer == TW'(TIMEOUT)) begin
            state_nxt = RELEASE;
            grant_nxt = '0;
            err_nxt   = 1'b1;
          end else begin
            timer_nxt = timer + 1'b1;
`endif
          end
        end
        CAST: begin
          state_nxt = RELEASE;
          grant_nxt = '0;
          if (code != VOTE_NONE) begin
            ack_nxt   = grant_q;
            count_nxt = (count_q == COUNT_MAX) ? count_q : count_q + 8'd1;
          end
        end
        RELEASE: begin
          state_nxt   = IDLE;
          pointer_nxt = (idx == IW'(NUM_BOOTHS - 1)) ? '0 : idx + 1'b1;
        end
        default: begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end
      endcase
    end
  end

  // State and registered outputs; asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      pointer <= '0;
      idx     <= '0;
      code    <= VOTE_NONE;
      grant_q <= '0;
      ack_q   <= '0;
      cand_q  <= 1'b0;
      c1_q    <= 1'b0;
      c2_q    <= 1'b0;
      c3_q    <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
`ifdef BOOTH_ARB_TIMEOUT_EN
      timer   <= '0;
`endif
    end else begin
      state   <= state_nxt;
      pointer <= pointer_nxt;
      idx     <= idx_nxt;
      code    <= code_nxt;
      grant_q <= grant_nxt;
      ack_q   <= ack_nxt;
      cand_q  <= cand_nxt;
      c1_q    <= c1_nxt;
      c2_q    <= c2_nxt;
      c3_q    <= c3_nxt;
      err_q   <= err_nxt;
      count_q <= count_nxt;
`ifdef BOOTH_ARB_TIMEOUT_EN
      timer   <= timer_nxt;
`endif
    end
  end

  assign bus.grant           = grant_q;
  assign bus.ack             = ack_q;
  assign bus.candidate_ready = cand_q;
  assign bus.vote_c1         = c1_q;
  assign bus.vote_c2         = c2_q;
  assign bus.vote_c3         = c3_q;
  assign bus.err             = err_q;
  assign bus.served_count    = count_q;
  assign bus.dbg_state       = state;
  assign bus.dbg_pointer     = pointer;

endmodule
